load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Core-side initiator for the word-wide data memory (comb read, posedge write, word addr = addr[31:2]).
//  Accepts lb/lh/lw/lbu/lhu/sb/sh/sw requests over a valid/ready handshake and sequences the memory port.
//  Sub-word stores are done as read-modify-write. Each request returns exactly one response pulse.
//  Sits between the execute stage and data memory.
// PARAMETERS
//  MEM_WORDS  1024  words in data memory; word index >= MEM_WORDS is an access fault
// PORTS
//  clk           in   1   clock; all state changes on posedge
//  rst           in   1   synchronous reset, active-high
//  req_valid     in   1   request present
//  req_ready     out  1   unit can accept a request (IDLE and !rst)
//  req_we        in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1   loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid    out  1   one-cycle response pulse
//  resp_rdata    out  32  extended load data; 0 for stores and errors
//  resp_err      out  1   misaligned, illegal size or out-of-range; valid with resp_valid
//  mem_we        out  1   memory write enable
//  mem_addr      out  32  {word_index,2'b00}; 0 when idle
//  mem_wd        out  32  memory write data
//  mem_rd        in   32  memory read data, combinational from mem_addr in the same cycle
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0, req_ready=0 while rst=1.
//  Handshake: accept when req_valid&&req_ready (cycle C); latch all req_* fields; req_ready=0 until back in IDLE.
//  Checks at accept: half with addr[0]=1, word with addr[1:0]!=0, size 11, or addr[31:2]>=MEM_WORDS -> error.
//  FSM states: IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP.
//   IDLE -> RESP on error (no memory access). Load -> LOAD. Word store -> STORE_W. Sub-word store -> RMW_RD.
//   LOAD: drive mem_addr; capture mem_rd; -> RESP.
//   STORE_W: mem_we=1, mem_wd=req_wdata; -> RESP.
//   RMW_RD: drive mem_addr; capture mem_rd into merge reg; -> RMW_WR.
//   RMW_WR: mem_we=1, mem_wd=merge reg with target lane replaced; -> RESP.
//   RESP: resp_valid=1 for exactly one cycle; -> IDLE (req_ready high the following cycle).
//  Latency (resp_valid cycle): error C+1; load and word store C+2; sub-word store C+3.
//  Lanes, little-endian: byte lane = addr[1:0] (bits 8*lane+7:8*lane); half lane = addr[1] (bits 16*addr[1]+15:16*addr[1]).
//  Load extension: byte/half sign- or zero-extended to 32 bits per req_unsigned. Word loads pass through unchanged.
//  mem_addr held stable for the whole access state. mem_we is never high outside STORE_W/RMW_WR.
//  Reset mid-operation: mem_we gated by !rst, so no write completes at a reset edge.
//   The in-flight request is dropped with no response.
//  req_valid while busy is ignored and not queued. Requester holds fields stable until accepted.
// TESTING
//  mem[1]=32'h8899AABB; lb addr 0x5 -> resp_rdata=32'hFFFFFFAA at C+2, err=0.
//  Same word; lhu addr 0x6 -> resp_rdata=32'h00008899. lh addr 0x6 -> 32'hFFFF8899.
//  mem[2]=32'h11223344; sb addr 0xA wdata 0xEE -> mem[2]=32'h11EE3344.
//   Check resp at C+3; one mem_we pulse, in cycle C+2.
//  sw addr 0x10 wdata 32'hDEADBEEF -> mem[4]=32'hDEADBEEF. resp at C+2, single mem_we pulse.
//  lw addr 0x2 -> resp_err=1 at C+1, no mem access.
//  lw addr 0x1000 with MEM_WORDS=1024 -> resp_err=1 at C+1.
//  size=11 -> resp_err=1 at C+1.
//  Assert rst during RMW_WR of sh addr 0x8 -> mem[2] unchanged, no resp_valid, req_ready=1 after reset released.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response handshake and data-memory port of the load/store unit
// slave is the unit itself; master is the core plus the memory it talks to.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
   );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store sequencer for a word-wide data memory
// Sub-word stores are read-modify-write; every accepted request yields one response pulse.
module load_store_unit #(
   parameter int MEM_WORDS = 1024
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STORE_W,
      RMW_RD,
      RMW_WR,
      RESP
   } state_t;

   localparam logic [29:0] LP_MEM_WORDS = 30'(MEM_WORDS);

   state_t      r_state;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [1:0]  r_lane;
   logic [15:0] r_wdata;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wd;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_err;

   logic        w_accept;
   logic        w_err;
   logic [4:0]  w_byte_sel;
   logic [4:0]  w_half_sel;
   logic [31:0] w_shifted;
   logic [31:0] w_load_ext;
   logic [31:0] w_merged;

   assign w_accept = bus.req_valid && bus.req_ready;

   assign w_err = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
               || (bus.req_addr[31:2] >= LP_MEM_WORDS);

   assign w_byte_sel = {r_lane, 3'b000};
   assign w_half_sel = {r_lane[1], 4'b0000};
   // Halves are always even-aligned here, so one shift serves both widths.
   assign w_shifted  = bus.mem_rd >> w_byte_sel;

   always_comb begin
      w_load_ext = bus.mem_rd;
      case (r_size)
         2'b00: w_load_ext = r_unsigned ? {24'h000000, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
         2'b01: w_load_ext = r_unsigned ? {16'h0000, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: w_load_ext = bus.mem_rd;
      endcase
   end

   always_comb begin
      w_merged = bus.mem_rd;
      case (r_size)
         2'b00:   w_merged[w_byte_sel +: 8]  = r_wdata[7:0];
         2'b01:   w_merged[w_half_sel +: 16] = r_wdata;
         default: w_merged = bus.mem_rd;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_size       <= 2'b00;
         r_unsigned   <= 1'b0;
         r_lane       <= 2'b00;
         r_wdata      <= 16'h0000;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 32'h0;
         r_mem_wd     <= 32'h0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_size     <= bus.req_size;
                  r_unsigned <= bus.req_unsigned;
                  r_lane     <= bus.req_addr[1:0];
                  r_wdata    <= bus.req_wdata[15:0];
                  if (w_err) begin
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_resp_rdata <= 32'h0;
                     r_state      <= RESP;
                  end else begin
                     r_mem_addr <= {bus.req_addr[31:2], 2'b00};
                     if (!bus.req_we) begin
                        r_state <= LOAD;
                     end else if (bus.req_size == 2'b10) begin
                        r_mem_we <= 1'b1;
                        r_mem_wd <= bus.req_wdata;
                        r_state  <= STORE_W;
                     end else begin
                        r_state <= RMW_RD;
                     end
                  end
               end
            end
            LOAD: begin
               r_resp_rdata <= w_load_ext;
               r_resp_err   <= 1'b0;
               r_resp_valid <= 1'b1;
               r_mem_addr   <= 32'h0;
               r_state      <= RESP;
            end
            STORE_W: begin
               r_mem_we     <= 1'b0;
               r_mem_wd     <= 32'h0;
               r_mem_addr   <= 32'h0;
               r_resp_rdata <= 32'h0;
               r_resp_err   <= 1'b0;
               r_resp_valid <= 1'b1;
               r_state      <= RESP;
            end
            RMW_RD: begin
               // Address stays put; the merged word is launched as the write beat.
               r_mem_wd <= w_merged;
               r_mem_we <= 1'b1;
               r_state  <= RMW_WR;
            end
            RMW_WR: begin
               r_mem_we     <= 1'b0;
               r_mem_wd     <= 32'h0;
               r_mem_addr   <= 32'h0;
               r_resp_rdata <= 32'h0;
               r_resp_err   <= 1'b0;
               r_resp_valid <= 1'b1;
               r_state      <= RESP;
            end
            RESP: begin
               r_resp_valid <= 1'b0;
               r_resp_rdata <= 32'h0;
               r_resp_err   <= 1'b0;
               r_state      <= IDLE;
            end
            default: begin
               r_mem_we     <= 1'b0;
               r_resp_valid <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   // Gating with !rst keeps a write from landing on the reset edge and zeroes
   // the outputs in the very first reset cycle, before the registers clear.
   assign bus.req_ready  = (r_state == IDLE) && !rst;
   assign bus.mem_we     = r_mem_we && !rst;
   assign bus.mem_addr   = rst ? 32'h0 : r_mem_addr;
   assign bus.mem_wd     = rst ? 32'h0 : r_mem_wd;
   assign bus.resp_valid = r_resp_valid && !rst;
   assign bus.resp_rdata = rst ? 32'h0 : r_resp_rdata;
   assign bus.resp_err   = r_resp_err && !rst;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
// A request-level model predicts response cycle, data, write beat and address window.
module tb_load_store_unit;
   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic init_mem = 1'b1;
   int   cyc      = 0;
   int   n_cmp    = 0;
   int   n_bad    = 0;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];

   int          exp_resp_cyc = -1;
   int          exp_we_cyc   = -1;
   int          busy_lo = 1, busy_hi = 0;
   int          acc_lo  = 1, acc_hi  = 0;
   logic [31:0] exp_rdata, exp_we_data, exp_word_addr, exp_prev_word;
   logic        exp_err;

   int          last_resp_cyc = -100;
   int          resp_count    = 0;
   int          we_total      = 0;
   logic [31:0] last_rdata;
   logic        last_err;

   load_store_unit_if bus ();

   load_store_unit #(.MEM_WORDS(1024)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int i);
      if (i == 1) return 32'h8899AABB;
      if (i == 2) return 32'h11223344;
      return 32'hA5A50000 | 32'(i);
   endfunction

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[11:2]] <= bus.mem_wd;
      end
   end
   assign bus.mem_rd = mem[bus.mem_addr[11:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
         chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
         chk("rst_resp_err",   32'(bus.resp_err), 32'd0);
         chk("rst_mem_we",     32'(bus.mem_we), 32'd0);
         chk("rst_mem_addr",   bus.mem_addr, 32'd0);
         chk("rst_mem_wd",     bus.mem_wd, 32'd0);
         chk("rst_req_ready",  32'(bus.req_ready), 32'd0);
      end else begin
         chk("req_ready",  32'(bus.req_ready), 32'(!(cyc >= busy_lo && cyc <= busy_hi)));
         chk("resp_valid", 32'(bus.resp_valid), 32'(cyc == exp_resp_cyc));
         if (bus.resp_valid) begin
            chk("resp_rdata", bus.resp_rdata, exp_rdata);
            chk("resp_err",   32'(bus.resp_err), 32'(exp_err));
            last_rdata    = bus.resp_rdata;
            last_err      = bus.resp_err;
            last_resp_cyc = cyc;
            resp_count++;
         end
         chk("mem_we", 32'(bus.mem_we), 32'(cyc == exp_we_cyc));
         if (bus.mem_we) begin
            chk("mem_wd", bus.mem_wd, exp_we_data);
            we_total++;
         end
         chk("mem_addr", bus.mem_addr, (cyc >= acc_lo && cyc <= acc_hi) ? exp_word_addr : 32'd0);
      end
   end

   task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata, input int c);
      int          idx;
      int          lane;
      int          lat;
      logic [31:0] word, field, mask, nw;
      idx  = int'(addr >> 2);
      lane = int'(addr & 32'h3);
      exp_err    = (size == 2'b11) || (size == 2'b01 && addr[0])
                || (size == 2'b10 && lane != 0) || (idx >= 1024);
      exp_rdata  = 32'd0;
      exp_we_cyc = -1;
      acc_lo = 1;
      acc_hi = 0;
      lat    = 1;
      if (!exp_err) begin
         word          = ref_mem[idx];
         exp_prev_word = word;
         exp_word_addr = 32'(idx) * 4;
         lat           = 2;
         if (!we) begin
            if (size == 2'b10) begin
               exp_rdata = word;
            end else begin
               field = (word >> (8 * lane)) & ((size == 2'b00) ? 32'hFF : 32'hFFFF);
               if (!uns && size == 2'b00 && field >= 32'h80)   field = field - 32'h100;
               if (!uns && size == 2'b01 && field >= 32'h8000) field = field - 32'h10000;
               exp_rdata = field;
            end
         end else if (size == 2'b10) begin
            nw         = wdata;
            exp_we_cyc = c + 1;
         end else begin
            lat        = 3;
            mask       = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << (8 * lane);
            nw         = (word & ~mask) | ((wdata << (8 * lane)) & mask);
            exp_we_cyc = c + 2;
         end
         if (we) begin
            exp_we_data  = nw;
            ref_mem[idx] = nw;
         end
         acc_lo = c + 1;
         acc_hi = c + lat - 1;
      end
      exp_resp_cyc = c + lat;
      busy_lo      = c + 1;
      busy_hi      = c + lat;
   endtask

   task automatic start_req(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata, output int c);
      int n = 0;
      while (!bus.req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.req_ready) chk("ready_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_valid    = 1'b1;
      c = cyc;
      model_req(we, size, uns, addr, wdata, c);
   endtask

   task automatic finish_req(input int hold);
      @(posedge clk); #1;
      // Fields scrambled while busy; the unit must ignore them.
      for (int i = 0; i < hold; i++) begin
         bus.req_we   = 1'b0;
         bus.req_addr = 32'h4;
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      while (cyc <= exp_resp_cyc) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run(input string name, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                      input logic [31:0] lit_rdata, input logic lit_err, input int lit_lat,
                      input int lit_pulses);
      int c, rc, wc;
      rc = resp_count;
      wc = we_total;
      start_req(we, size, uns, addr, wdata, c);
      finish_req(hold);
      chk({name, "_nresp"},  32'(resp_count - rc), 32'd1);
      chk({name, "_lat"},    32'(last_resp_cyc - c), 32'(lit_lat));
      chk({name, "_rdata"},  last_rdata, lit_rdata);
      chk({name, "_err"},    32'(last_err), 32'(lit_err));
      chk({name, "_pulses"}, 32'(we_total - wc), 32'(lit_pulses));
   endtask

   initial begin
      int c, rc, wc;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      init_mem = 1'b0;
      #1;
      chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;

      run("lb_5",   1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 0, 32'hFFFFFFAA, 1'b0, 2, 0);
      run("lhu_6",  1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 0, 32'h00008899, 1'b0, 2, 0);
      run("lh_6",   1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 0, 32'hFFFF8899, 1'b0, 2, 0);
      run("lbu_4",  1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 0, 32'h000000BB, 1'b0, 2, 0);
      run("lb_7",   1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 0, 32'hFFFFFF88, 1'b0, 2, 0);
      run("lw_4",   1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0, 32'h8899AABB, 1'b0, 2, 0);
      run("sb_A",   1'b1, 2'b00, 1'b0, 32'hA, 32'hEE, 2, 32'h0, 1'b0, 3, 1);
      chk("sb_A_mem2", mem[2], 32'h11EE3344);
      run("sw_10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0, 2, 1);
      chk("sw_10_mem4", mem[4], 32'hDEADBEEF);
      run("sh_E",   1'b1, 2'b01, 1'b0, 32'hE, 32'h1234ABCD, 0, 32'h0, 1'b0, 3, 1);
      chk("sh_E_mem3", mem[3], 32'hABCD0003);
      run("sb_4",   1'b1, 2'b00, 1'b0, 32'h4, 32'hFFFFFF77, 1, 32'h0, 1'b0, 3, 1);
      run("lw_4b",  1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0, 32'h8899AA77, 1'b0, 2, 0);
      run("lw_2e",  1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 0, 32'h0, 1'b1, 1, 0);
      run("lw_oob", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0, 32'h0, 1'b1, 1, 0);
      run("sz3_e",  1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1, 0);
      run("lh_5e",  1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 0, 32'h0, 1'b1, 1, 0);
      run("sh_oob", 1'b1, 2'b01, 1'b0, 32'h1002, 32'h1, 0, 32'h0, 1'b1, 1, 0);
      run("lw_8",   1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, 32'h11EE3344, 1'b0, 2, 0);

      rc = resp_count;
      wc = we_total;
      start_req(1'b1, 2'b01, 1'b0, 32'h8, 32'h5555, c);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      rst           = 1'b1;
      ref_mem[2]    = exp_prev_word;
      exp_resp_cyc  = -1;
      exp_we_cyc    = -1;
      busy_lo = 1;
      busy_hi = 0;
      acc_lo  = 1;
      acc_hi  = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      chk("rst_mid_mem2",   mem[2], 32'h11EE3344);
      chk("rst_mid_nresp",  32'(resp_count - rc), 32'd0);
      chk("rst_mid_pulses", 32'(we_total - wc), 32'd0);

      run("lh_A",   1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 0, 32'h000011EE, 1'b0, 2, 0);

      for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
